// File: rtl/ram_dp_hs.sv
// ram_dp_hs: parametrised true dual-port RAM with request/grant handshake.
// Port A has fixed priority; a same-address pair involving a write stalls B
// for one cycle and bumps a saturating debug counter. Each port owns a small
// response pipeline (1 or 2 cycles) that also implements its write mode.

// Per-port response pipeline: turns accepted accesses into rvalid/rdata pulses.
module ram_dp_hs_port #(
    parameter int DATA_W  = 8,
    parameter int WMODE   = 0,   // 0 normal, 1 write-through, 2 read-before-write
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc,      // access accepted on this edge
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rd_word,  // memory word at the port address, pre-write
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    logic                          vld_in;
    logic [STAGES:1]               vld_pipe;
    logic [STAGES:1][DATA_W-1:0]   dat_pipe;
    logic [DATA_W-1:0]             resp_d;

    // Reads always respond; writes respond only in write-through / read-before-write.
    assign vld_in = acc && (!we || (WMODE != 0));

    // Write-through returns the new word; reads and read-before-write return
    // the word as it was before this edge's write.
    assign resp_d = (we && (WMODE == 1)) ? wdata : rd_word;

    // Valid shift register with data stages that only load on a valid, so
    // rdata holds its last response across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld_in;
            if (vld_in)
                dat_pipe[1] <= resp_d;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1])
                    dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rvalid = vld_pipe[STAGES];
    assign rdata  = dat_pipe[STAGES];

endmodule

// Top: storage array, B-stall arbitration, collision counter, two port pipelines.
module ram_dp_hs #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 13,
    parameter int OUT_REG = 0,
    parameter int WMODE_A = 0,
    parameter int WMODE_B = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam int NUM_PORTS = 2;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t [NUM_PORTS-1:0]              rq;
    logic [NUM_PORTS-1:0]              acc;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rd_word;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_v;
    logic [NUM_PORTS-1:0]              rvalid_v;
    logic                              collide;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rq[0] = {a_req, a_we, a_addr, a_wdata};
    assign rq[1] = {b_req, b_we, b_addr, b_wdata};

    // Only a same-address pair with at least one write conflicts; A always wins.
    assign collide = rq[0].req && rq[1].req && (rq[0].addr == rq[1].addr)
                     && (rq[0].we || rq[1].we);

    assign acc[0] = rq[0].req;
    assign acc[1] = rq[1].req && !collide;

    assign a_gnt = acc[0];
    assign b_gnt = acc[1];

    // Storage write; contents survive reset. Both ports never write the same
    // word on one edge because B is stalled in that case.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p] && rq[p].we)
                mem[rq[p].addr] <= rq[p].wdata;
        end
    end

    // Saturating count of cycles in which B was stalled by a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_cnt <= '0;
        else if (collide && !(&coll_cnt))
            coll_cnt <= coll_cnt + 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            assign rd_word[g] = mem[rq[g].addr];

            ram_dp_hs_port #(
                .DATA_W  (DATA_W),
                .WMODE   ((g == 0) ? WMODE_A : WMODE_B),
                .OUT_REG (OUT_REG)
            ) u_port (
                .clk     (clk),
                .rst_n   (rst_n),
                .acc     (acc[g]),
                .we      (rq[g].we),
                .wdata   (rq[g].wdata),
                .rd_word (rd_word[g]),
                .rvalid  (rvalid_v[g]),
                .rdata   (rdata_v[g])
            );
        end
    endgenerate

    assign a_rvalid = rvalid_v[0];
    assign a_rdata  = rdata_v[0];
    assign b_rvalid = rvalid_v[1];
    assign b_rdata  = rdata_v[1];

endmodule

// File: doc/ram_dp_hs.md
Name: ram_dp_hs

Overview:
- Parametrised true dual-port RAM, single clock domain; successor to the fixed 8k x 8 dual-port block.
- Two identical request/grant ports (A, B) with configurable data width, depth, read latency and per-port write mode.
- Same-address write collisions are resolved by a fixed-priority arbiter that stalls the losing port, with a saturating collision counter for debug.
- Sits between platform bus masters and inferred block RAM.

Parameters:
- DATA_W, 8, data width per word (1..36).
- ADDR_W, 13, address width; depth = 2**ADDR_W words.
- OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles.
- WMODE_A, 0, port A write mode: 0 normal (rdata unchanged on write), 1 write-through, 2 read-before-write.
- WMODE_B, 0, port B write mode, same encoding as WMODE_A.
- CNT_W, 16, collision counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0); qualified by a_req.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: as for port A.
- coll_cnt  out  CNT_W  saturating count of B stalls caused by collisions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_rvalid, b_rvalid, a_rdata, b_rdata, coll_cnt, and all pipeline registers go to 0.
  - Memory contents are not cleared.
- Accepting a request:
  - An access is accepted on a rising edge where req && gnt. Requesters hold req, we, addr and wdata stable until gnt is seen.
- Grant:
  - a_gnt = a_req, always; port A is never stalled.
  - b_gnt = b_req && !collide, where collide = a_req && b_req && (a_addr == b_addr) && (a_we || b_we).
  - Any same-address pair involving a write stalls B for one cycle. B is re-evaluated the next cycle.
- Write: memory updated at the accepting edge.
- Read-type response: generated by an accepted read, or by an accepted write when WMODE is 1 or 2.
  - OUT_REG=0: rvalid high and rdata valid in the cycle after the accepting edge.
  - OUT_REG=1: one cycle later still.
  - Responses come out in acceptance order, one per accepted access; back-to-back accesses give back-to-back rvalid pulses. No backpressure on responses.
- Write modes:
  - WMODE 0: a write produces no rvalid; rdata holds its last value.
  - WMODE 1: rvalid pulses with rdata = wdata.
  - WMODE 2: rvalid pulses with rdata = the word's prior contents.
- Cross-port reads: never at the same address in the same cycle, because B is stalled. A read that follows a write from the other port on a later edge returns the new data.
- rdata is held between responses. Neither rdata nor rvalid changes on an idle cycle, except that rvalid drops to 0 after its pulse.
- Different-address simultaneous accesses: both are granted, with no interaction.
- coll_cnt: increments by 1 each cycle collide is high; it saturates at all ones and never wraps.
- Reset mid-operation:
  - Pending pipeline responses are discarded (rvalid held 0).
  - A write accepted on the same edge as reset assertion is not guaranteed.
- Out-of-range addresses: impossible, since depth is exactly 2**ADDR_W.

Test Plan:
- Reset then idle (OUT_REG=0): all outputs 0. Write A 0x0010=0xA5; read B 0x0010 -> b_rvalid one cycle after accept, b_rdata=0xA5; a_rvalid never pulses (WMODE_A=0).
- Collision: A write 0x0100=0x11 and B write 0x0100=0x22 same cycle -> a_gnt=1, b_gnt=0, coll_cnt=1. Next cycle b_gnt=1. Final read 0x0100 = 0x22.
- A write 0x0200=0x33 with B read 0x0200 same cycle -> B stalled one cycle, then returns 0x33. Simultaneous A read 0x0001 and B read 0x0001 -> both granted, no stall, coll_cnt unchanged.
- WMODE_A=2, OUT_REG=1: preload 0x0005=0x5A. A write 0x0005=0xC3 -> a_rvalid two cycles after accept, a_rdata=0x5A. WMODE_A=1 repeat -> a_rdata=0xC3.
- Streaming: A reads addresses 0..7, one per cycle, OUT_REG=1 -> 8 consecutive rvalid pulses, in order, data matching a preload pattern (addr XOR 0x5C). Assert rst_n mid-stream -> rvalid low immediately, rdata=0, and no stale responses after release.
- CNT_W=4: force 20 consecutive collisions -> coll_cnt saturates at 15 and holds.
